// File: rtl/serial_p2s_receiver.sv
// Serial-to-parallel receiver for the sclk/sout/sclrn/latch-enable shift-chain protocol.
// All serial lines are oversampled in the clk domain and reassembled into a DATA_BITS word.
module serial_p2s_receiver #(
    parameter int unsigned DATA_BITS       = 16,
    parameter int unsigned DATA_COUNT_BITS = 5,
    parameter bit          DIR             = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sclk,
    input  logic                       sdin,
    input  logic                       sclrn,
    input  logic                       EN,
    output logic [DATA_BITS-1:0]       PData,
    output logic                       valid,
    output logic                       frame_err,
    output logic                       busy,
    output logic [DATA_COUNT_BITS-1:0] bit_cnt
);

    localparam logic [DATA_COUNT_BITS-1:0] CntFull = DATA_COUNT_BITS'(DATA_BITS);
    localparam logic [DATA_COUNT_BITS-1:0] CntOvr  = DATA_COUNT_BITS'(DATA_BITS + 1);
    localparam logic [DATA_COUNT_BITS-1:0] CntOne  = DATA_COUNT_BITS'(1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StLatch
    } state_e;

    // Line order in the sync vectors: {EN, sclrn, sdin, sclk}.
    logic [3:0] meta_q;
    logic [3:0] sync_q;
    logic [1:0] hist_q;

    logic sclk_rise;
    logic en_rise;
    logic sdin_s;
    logic clr;

    state_e                     state_q, state_d;
    logic [DATA_BITS-1:0]       sr_q, sr_d;
    logic [DATA_BITS-1:0]       sr_shifted;
    logic [DATA_COUNT_BITS-1:0] cnt_q, cnt_d;
    logic [DATA_COUNT_BITS-1:0] cnt_inc;
    logic [DATA_BITS-1:0]       pdata_q, pdata_d;
    logic                       valid_q, valid_d;
    logic                       ferr_q, ferr_d;

    // sdin and sclrn share the same two-stage delay as sclk, so sdin stays aligned to sclk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
            hist_q <= '0;
        end else begin
            meta_q <= {EN, sclrn, sdin, sclk};
            sync_q <= meta_q;
            hist_q <= {sync_q[3], sync_q[0]};
        end
    end

    assign sclk_rise = sync_q[0] & ~hist_q[0];
    assign en_rise   = sync_q[3] & ~hist_q[1];
    assign sdin_s    = sync_q[1];
    assign clr       = ~sync_q[2];

    generate
        if (DIR) begin : g_lsb_first
            assign sr_shifted = {sdin_s, sr_q[DATA_BITS-1:1]};
        end else begin : g_msb_first
            assign sr_shifted = {sr_q[DATA_BITS-2:0], sdin_s};
        end
    endgenerate

    // Saturate one past full so an overrun cannot wrap back to a legal count.
    assign cnt_inc = (cnt_q == CntOvr) ? cnt_q : cnt_q + CntOne;

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        pdata_d = pdata_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        if (clr) begin
            state_d = StIdle;
            sr_d    = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (sclk_rise) begin
                        sr_d    = sr_shifted;
                        cnt_d   = cnt_inc;
                        // Coincident latch is evaluated next cycle on the post-shift count.
                        state_d = en_rise ? StLatch : StShift;
                    end else if (en_rise) begin
                        ferr_d = 1'b1;
                    end
                end
                StShift: begin
                    if (sclk_rise) begin
                        sr_d  = sr_shifted;
                        cnt_d = cnt_inc;
                    end
                    if (en_rise) begin
                        state_d = StLatch;
                    end
                end
                StLatch: begin
                    if (cnt_q == CntFull) begin
                        pdata_d = sr_q;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                    cnt_d   = '0;
                    state_d = StIdle;
                    // The next frame may start in the latch cycle itself.
                    if (sclk_rise) begin
                        sr_d    = sr_shifted;
                        cnt_d   = CntOne;
                        state_d = en_rise ? StLatch : StShift;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            sr_q    <= '0;
            cnt_q   <= '0;
            pdata_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            pdata_q <= pdata_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign PData     = pdata_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != StIdle);
    assign bit_cnt   = cnt_q;

endmodule

// File: tb/tb_serial_p2s_receiver.sv
// Bench for serial_p2s_receiver: MSB-first and LSB-first instances share the serial lines;
// a scoreboard of expected latch outcomes is checked by a monitor on every output pulse.
module tb_serial_p2s_receiver;

    logic        clk = 1'b0;
    logic        rst;
    logic        sclk;
    logic        sdin;
    logic        sclrn;
    logic        en;
    logic [15:0] pd0, pd1;
    logic        v0, v1, fe0, fe1, b0, b1;
    logic [4:0]  bc0, bc1;

    int checks   = 0;
    int failures = 0;

    logic [16:0] q0[$];
    logic [16:0] q1[$];
    logic [15:0] last0, last1;
    bit          frame_bits[$];

    always #5 clk = ~clk;

    serial_p2s_receiver #(
        .DATA_BITS      (16),
        .DATA_COUNT_BITS(5),
        .DIR            (1'b0)
    ) dut0 (
        .clk      (clk),
        .rst      (rst),
        .sclk     (sclk),
        .sdin     (sdin),
        .sclrn    (sclrn),
        .EN       (en),
        .PData    (pd0),
        .valid    (v0),
        .frame_err(fe0),
        .busy     (b0),
        .bit_cnt  (bc0)
    );

    serial_p2s_receiver #(
        .DATA_BITS      (16),
        .DATA_COUNT_BITS(5),
        .DIR            (1'b1)
    ) dut1 (
        .clk      (clk),
        .rst      (rst),
        .sclk     (sclk),
        .sdin     (sdin),
        .sclrn    (sclrn),
        .EN       (en),
        .PData    (pd1),
        .valid    (v1),
        .frame_err(fe1),
        .busy     (b1),
        .bit_cnt  (bc1)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    // Pops one expected outcome per output pulse.
    task automatic mon(input int inst, input logic v, input logic fe, input logic [15:0] pd);
        logic [16:0] e;
        int          qs;
        if (v || fe) begin
            chk($sformatf("pulse_excl%0d", inst), {63'd0, v & fe}, 64'd0);
            qs = (inst == 0) ? q0.size() : q1.size();
            if (qs == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse%0d: got valid=%0b frame_err=%0b required none",
                         inst, v, fe);
            end else begin
                if (inst == 0) e = q0.pop_front();
                else           e = q1.pop_front();
                chk($sformatf("pulse_kind%0d", inst), {62'd0, v, fe},
                    e[16] ? 64'd1 : 64'd2);
                if (!e[16]) begin
                    chk($sformatf("pdata%0d", inst), pd, e[15:0]);
                    if (inst == 0) last0 = e[15:0];
                    else           last1 = e[15:0];
                end else begin
                    chk($sformatf("pdata_hold%0d", inst), pd, (inst == 0) ? last0 : last1);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(0, v0, fe0, pd0);
            mon(1, v1, fe1, pd1);
        end
    end

    task automatic send_bit(input bit b);
        @(negedge clk);
        sdin = b;
        repeat (3) @(negedge clk);
        sclk = 1'b1;
        repeat (4) @(negedge clk);
        sclk = 1'b0;
        frame_bits.push_back(b);
    endtask

    task automatic send_word(input logic [15:0] w, input int n, input bit lsb_first);
        for (int i = 0; i < n; i++) begin
            send_bit(lsb_first ? w[i] : w[n-1-i]);
        end
    endtask

    // A frame is good only with exactly 16 bits; the first bit is the MSB for DIR=0,
    // the LSB for DIR=1.
    task automatic push_expect();
        int          n;
        logic [15:0] w0, w1;
        n  = frame_bits.size();
        w0 = '0;
        w1 = '0;
        if (n == 16) begin
            for (int i = 0; i < 16; i++) begin
                w0[15-i] = frame_bits[i];
                w1[i]    = frame_bits[i];
            end
            q0.push_back({1'b0, w0});
            q1.push_back({1'b0, w1});
        end else begin
            q0.push_back({1'b1, 16'h0});
            q1.push_back({1'b1, 16'h0});
        end
        frame_bits.delete();
    endtask

    task automatic do_latch();
        push_expect();
        repeat (4) @(negedge clk);
        en = 1'b1;
        repeat (4) @(negedge clk);
        en = 1'b0;
        repeat (4) @(negedge clk);
        chk("drained0", 64'(q0.size()), 64'd0);
        chk("drained1", 64'(q1.size()), 64'd0);
        chk("cnt_after_latch", {59'd0, bc0}, 64'd0);
        chk("busy_after_latch", {63'd0, b1}, 64'd0);
    endtask

    task automatic do_clear();
        sclrn = 1'b0;
        repeat (4) @(negedge clk);
        sclrn = 1'b1;
        repeat (4) @(negedge clk);
        frame_bits.delete();
    endtask

    initial begin
        int r;
        int n;
        logic [15:0] w;

        rst   = 1'b1;
        sclk  = 1'b0;
        sdin  = 1'b0;
        sclrn = 1'b1;
        en    = 1'b0;
        last0 = '0;
        last1 = '0;
        #1;
        chk("rst_pdata", {48'd0, pd0}, 64'd0);
        chk("rst_valid", {63'd0, v0}, 64'd0);
        chk("rst_ferr", {63'd0, fe0}, 64'd0);
        chk("rst_busy", {63'd0, b0}, 64'd0);
        chk("rst_cnt", {59'd0, bc0}, 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        send_word(16'hA55A, 16, 1'b0);
        do_latch();
        chk("basic_msb", {48'd0, pd0}, 64'hA55A);

        send_word(16'h80FF, 16, 1'b1);
        do_latch();
        chk("basic_lsb", {48'd0, pd1}, 64'h80FF);

        send_word(16'h1234, 15, 1'b0);
        do_latch();

        send_bit(1'b0);
        send_word(16'h1234, 16, 1'b0);
        chk("overrun_cnt", {59'd0, bc0}, 64'd17);
        do_latch();

        send_word(16'h00FF, 8, 1'b0);
        chk("mid_cnt", {59'd0, bc0}, 64'd8);
        chk("mid_busy", {63'd0, b0}, 64'd1);
        do_clear();
        chk("clr_cnt", {59'd0, bc0}, 64'd0);
        chk("clr_busy", {63'd0, b0}, 64'd0);
        send_word(16'hFFFF, 16, 1'b0);
        do_latch();
        chk("after_clr", {48'd0, pd0}, 64'hFFFF);

        // Zero-bit latch from idle.
        do_latch();

        send_word(16'h03FF, 10, 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mrst_pdata", {48'd0, pd0}, 64'd0);
        chk("mrst_pdata1", {48'd0, pd1}, 64'd0);
        chk("mrst_busy", {63'd0, b0}, 64'd0);
        chk("mrst_cnt", {59'd0, bc0}, 64'd0);
        chk("mrst_pulses", {62'd0, v0, fe0}, 64'd0);
        frame_bits.delete();
        last0 = '0;
        last1 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        send_word(16'h5455, 16, 1'b0);
        do_latch();
        chk("after_rst", {48'd0, pd0}, 64'h5455);

        for (int it = 0; it < 16; it++) begin
            w = 16'($urandom);
            r = int'($urandom_range(0, 7));
            n = (r == 0) ? 0 : (r == 1) ? 15 : (r == 2) ? 17 : 16;
            if ($urandom_range(0, 5) == 0) begin
                send_word(16'($urandom), int'($urandom_range(1, 12)), 1'b0);
                do_clear();
            end
            if (n == 17) begin
                send_bit(1'($urandom));
                n = 16;
            end
            send_word(w, n, 1'($urandom));
            do_latch();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
